miriscv_lsu: RTL

Load/store unit between the core's execute stage and the data memory port. Converts a core load/store (byte address, size code, raw store data) into a word-aligned memory transaction with byte enables over a req/gnt/rvalid handshake. Stalls the core until the transaction completes, then returns the sign- or zero-extended load result. Flags misaligned or illegal accesses and memory timeouts.

---
 rtl/miriscv_lsu_if.sv | 22 ++
 rtl/miriscv_lsu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu_if.sv
// Data memory port of the load/store unit: word-aligned req/gnt/rvalid bus.
// Signal names keep the LSU-side _i/_o suffixes of the original flat ports.
interface miriscv_lsu_if;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/miriscv_lsu.sv
// Load/store unit: turns a core byte-addressed access into a word-aligned
// memory transaction, stalls the core until completion and extends loads.
module miriscv_lsu #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lsu_req_i,
    input  logic               lsu_we_i,
    input  logic [2:0]         lsu_size_i,
    input  logic [31:0]        lsu_addr_i,
    input  logic [31:0]        lsu_data_i,
    output logic               lsu_stall_req_o,
    output logic [31:0]        lsu_data_o,
    output logic               lsu_misalign_o,
    output logic               lsu_timeout_o,
    miriscv_lsu_if.master      data_if
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [7:0] CNT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        timeout_q, timeout_d;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    logic        legal;
    logic        capture;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    // Sizes 4/5 are unsigned loads only; a store with those codes is illegal.
    always_comb begin
        legal = 1'b0;
        case (lsu_size_i)
            3'd0:    legal = 1'b1;
            3'd1:    legal = ~lsu_addr_i[0];
            3'd2:    legal = (lsu_addr_i[1:0] == 2'b00);
            3'd4:    legal = ~lsu_we_i;
            3'd5:    legal = ~lsu_we_i & ~lsu_addr_i[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = lsu_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << lsu_addr_i[1:0];
                wdata_new = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_new = {2{lsu_data_i[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = lsu_data_i;
            end
        endcase
    end

    always_comb begin
        rd_byte  = 8'(data_if.data_rdata_i >> {off_q, 3'b000});
        rd_half  = 16'(data_if.data_rdata_i >> {off_q[1], 4'b0000});
        load_val = data_if.data_rdata_i;
        case (size_q)
            3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_val = {24'd0, rd_byte};
            3'd5:    load_val = {16'd0, rd_half};
            default: load_val = data_if.data_rdata_i;
        endcase
    end

    // The limit check wins over a same-cycle gnt so REQ+RESP never exceeds MEM_TIMEOUT cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        timeout_d = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_req_i && legal) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    capture = 1'b1;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LIMIT) begin
                    state_d   = DONE;
                    data_d    = '0;
                    timeout_d = 1'b1;
                end else if (data_if.data_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (data_if.data_rvalid_i) begin
                    state_d = DONE;
                    data_d  = we_q ? '0 : load_val;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d   = DONE;
                    data_d    = '0;
                    timeout_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
            if (capture) begin
                we_q    <= lsu_we_i;
                size_q  <= lsu_size_i;
                off_q   <= lsu_addr_i[1:0];
                addr_q  <= {lsu_addr_i[31:2], 2'b00};
                be_q    <= be_new;
                wdata_q <= wdata_new;
            end
        end
    end

    assign lsu_stall_req_o = ((state_q == IDLE) && lsu_req_i && legal)
                           || (state_q == REQ) || (state_q == RESP);
    assign lsu_misalign_o  = (state_q == IDLE) && lsu_req_i && !legal;
    assign lsu_data_o      = data_q;
    assign lsu_timeout_o   = timeout_q;

    assign data_if.data_req_o   = (state_q == REQ);
    assign data_if.data_we_o    = we_q;
    assign data_if.data_be_o    = be_q;
    assign data_if.data_addr_o  = addr_q;
    assign data_if.data_wdata_o = wdata_q;

endmodule
